// File: rtl/wb_ram512x8_ctrl.sv
// Wishbone slave that splits each 32-bit access into four byte accesses on a 512x8 sync RAM.
// Write ack 5 cycles after accept, read ack 6; no backpressure, dropping wb_cyc_i aborts.
module wb_ram512x8_ctrl (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [6:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        ram_wen_o,
  output logic [8:0]  ram_adr_o,
  output logic [7:0]  ram_dat_o,
  input  logic [7:0]  ram_dat_i
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_LAST, ACK} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [6:0]  adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [23:0] rd_q;
  logic        req;

  assign req = wb_cyc_i & wb_stb_i;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      k        <= 2'd0;
      adr_q    <= 7'd0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      rd_q     <= 24'd0;
      wb_dat_o <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb_adr_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            k     <= 2'd0;
          end
        end
        WR: k <= k + 2'd1;
        RD: begin
          k <= k + 2'd1;
          // RAM data lags its address by one cycle, so byte k-1 arrives while k is presented.
          case (k)
            2'd1:    rd_q[7:0]   <= ram_dat_i;
            2'd2:    rd_q[15:8]  <= ram_dat_i;
            2'd3:    rd_q[23:16] <= ram_dat_i;
            default: ;
          endcase
        end
        RD_LAST: begin
          // The visible read word only changes when a read completes.
          if (wb_cyc_i) wb_dat_o <= {ram_dat_i, rd_q};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wb_ack_o  = 1'b0;
    ram_wen_o = 1'b0;
    ram_adr_o = 9'd0;
    ram_dat_o = 8'd0;
    case (state)
      IDLE: begin
        if (req) state_nxt = wb_we_i ? WR : RD;
      end
      WR: begin
        ram_adr_o = {adr_q, k};
        ram_dat_o = dat_q[{k, 3'b000} +: 8];
        ram_wen_o = sel_q[k];
        if (!wb_cyc_i)      state_nxt = IDLE;
        else if (k == 2'd3) state_nxt = ACK;
      end
      RD: begin
        ram_adr_o = {adr_q, k};
        if (!wb_cyc_i)      state_nxt = IDLE;
        else if (k == 2'd3) state_nxt = RD_LAST;
      end
      RD_LAST: begin
        state_nxt = wb_cyc_i ? ACK : IDLE;
      end
      ACK: begin
        wb_ack_o  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ram512x8_ctrl.sv
// Randomized bench for wb_ram512x8_ctrl: a behavioural 512x8 RAM plus a word-level golden memory.
module tb_wb_ram512x8_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [6:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        ram_wen_o;
  logic [8:0]  ram_adr_o;
  logic [7:0]  ram_dat_o;
  logic [7:0]  ram_dat_i;

  wb_ram512x8_ctrl dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .ram_wen_o(ram_wen_o),
    .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o),
    .ram_dat_i(ram_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM: write on the edge, read data one cycle after the address.
  logic [7:0] mem [0:511];
  always @(posedge clk_i) begin
    if (ram_wen_o) mem[ram_adr_o] <= ram_dat_o;
    ram_dat_i <= mem[ram_adr_o];
  end

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  logic [31:0] gold [0:127];
  logic [31:0] last_rd;
  logic [6:0]  pool [12];
  int          checks = 0;
  int          failures = 0;
  int          last_ack = 0;
  bit          prev_chain = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ack"}, wb_ack_o, 0);
    chk({tag, "_wen"}, ram_wen_o, 0);
    chk({tag, "_adr"}, ram_adr_o, 0);
    chk({tag, "_wdat"}, ram_dat_o, 0);
  endtask

  // Full transfer; called at a negedge with the block idle, returns at the negedge of the post-ack IDLE cycle.
  task automatic xfer(input bit we, input logic [6:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input bit chain);
    int last;
    last = we ? 5 : 6;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    @(posedge clk_i);
    for (int t = 1; t < last; t++) begin
      @(negedge clk_i);
      if (t == 1) begin
        wb_stb_i = 1'($urandom); wb_we_i = 1'($urandom);
        wb_adr_i = 7'($urandom); wb_sel_i = 4'($urandom); wb_dat_i = $urandom;
      end
      if (t <= 4) begin
        chk("ram_adr", ram_adr_o, {adr, 2'(t - 1)});
        chk("ram_wen", ram_wen_o, we ? sel[t - 1] : 1'b0);
        chk("ram_wdat", ram_dat_o, we ? dat[8 * (t - 1) +: 8] : 8'd0);
      end
      chk("ack_early", wb_ack_o, 0);
    end
    @(negedge clk_i);
    chk("ack", wb_ack_o, 1);
    if (prev_chain) chk("ack_spacing", cyc_cnt - last_ack, we ? 6 : 7);
    last_ack   = cyc_cnt;
    prev_chain = chain;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) gold[adr][8 * b +: 8] = dat[8 * b +: 8];
      chk("rdat_hold", wb_dat_o, last_rd);
    end else begin
      chk("rdat", wb_dat_o, gold[adr]);
      last_rd = gold[adr];
    end
    if (chain) wb_stb_i = 1;
    else begin wb_cyc_i = 0; wb_stb_i = 0; end
    @(negedge clk_i);
    idle_outputs("post_ack");
  endtask

  // Drop wb_cyc_i during transfer cycle n (1-based).
  task automatic abort_xfer(input bit we, input logic [6:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input int n);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    @(posedge clk_i);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk_i);
      if (t <= 4) chk("abort_adr", ram_adr_o, {adr, 2'(t - 1)});
      chk("abort_ack", wb_ack_o, 0);
      if (t == n) begin wb_cyc_i = 0; wb_stb_i = 0; end
    end
    if (we)
      for (int b = 0; b < n; b++)
        if (sel[b]) gold[adr][8 * b +: 8] = dat[8 * b +: 8];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      idle_outputs("after_abort");
      chk("abort_rdat", wb_dat_o, last_rd);
    end
    prev_chain = 0;
  endtask

  // Cycles where wb_cyc_i and wb_stb_i are never both high.
  task automatic idle(input int n);
    if ($urandom_range(0, 1) == 1) begin wb_cyc_i = 1; wb_stb_i = 0; end
    else begin wb_cyc_i = 0; wb_stb_i = 1; end
    wb_we_i = 1'($urandom);
    repeat (n) begin
      @(negedge clk_i);
      chk("idle_ack", wb_ack_o, 0);
      chk("idle_wen", ram_wen_o, 0);
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    prev_chain = 0;
  endtask

  initial begin
    rst_in = 0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = 0; wb_sel_i = 0; wb_dat_i = 0;
    last_rd = 0;
    for (int i = 0; i < 128; i++) gold[i] = 32'd0;
    pool = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd5, 7'd6, 7'd7, 7'd42, 7'd64, 7'd100, 7'd126, 7'd127};

    repeat (3) @(negedge clk_i);
    idle_outputs("reset");
    chk("reset_rdat", wb_dat_o, 0);
    rst_in = 1;
    @(negedge clk_i);

    foreach (pool[i]) xfer(1, pool[i], 4'hF, $urandom, 0);

    // Reference write/read of word 5.
    xfer(1, 7'd5, 4'hF, 32'hA1B2C3D4, 0);
    xfer(0, 7'd5, 4'h0, 32'h0, 0);
    chk("word5", last_rd, 32'hA1B2C3D4);

    // Top word, sparse byte enables.
    xfer(1, 7'd127, 4'hF, 32'hFFFF_FFFF, 0);
    xfer(1, 7'd127, 4'b0101, 32'h11223344, 0);
    xfer(0, 7'd127, 4'hF, 32'h0, 0);
    chk("word127", last_rd, 32'hFF22_FF44);

    // Write aborted after two bytes, then a normal read.
    abort_xfer(1, 7'd3, 4'hF, 32'h5566_7788, 2);
    xfer(0, 7'd3, 4'hF, 32'h0, 0);
    abort_xfer(0, 7'd5, 4'hF, 32'h0, 2);
    abort_xfer(0, 7'd5, 4'hF, 32'h0, 5);

    // Reset during read cycle t3.
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 7'd5;
    @(posedge clk_i);
    repeat (3) @(negedge clk_i);
    chk("rst_pre_adr", ram_adr_o, {7'd5, 2'd2});
    rst_in = 0;
    #1;
    idle_outputs("midreset");
    chk("midreset_rdat", wb_dat_o, 0);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk_i);
    chk("midreset_ack", wb_ack_o, 0);
    rst_in = 1;
    last_rd = 0;
    prev_chain = 0;
    @(negedge clk_i);
    xfer(1, 7'd64, 4'b1001, $urandom, 0);
    xfer(0, 7'd5, 4'hF, 32'h0, 0);
    chk("post_reset_word5", last_rd, 32'hA1B2C3D4);

    // Back-to-back transfers with the request held.
    xfer(1, 7'd6, 4'hF, $urandom, 1);
    xfer(1, 7'd7, 4'hF, $urandom, 1);
    xfer(0, 7'd6, 4'hF, 32'h0, 1);
    xfer(0, 7'd7, 4'hF, 32'h0, 0);

    for (int it = 0; it < 80; it++) begin
      int sel_case;
      logic [6:0] a;
      bit w;
      a = pool[$urandom_range(0, 11)];
      w = 1'($urandom);
      sel_case = $urandom_range(0, 9);
      if (sel_case < 2) idle($urandom_range(1, 3));
      if (sel_case == 9)
        abort_xfer(w, a, 4'($urandom), $urandom, w ? $urandom_range(1, 4) : $urandom_range(1, 5));
      else
        xfer(w, a, 4'($urandom), $urandom, 1'($urandom));
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ram512x8_ctrl.md
WB_RAM512X8_CTRL -- requirements
Module: wb_ram512x8_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-004 wb_cyc_i  input  1  Wishbone classic cycle.
REQ-005 wb_stb_i  input  1  Wishbone strobe.
REQ-006 wb_we_i  input  1  1 = write, 0 = read.
REQ-007 wb_adr_i  input  7  32-bit word address (word 0..127).
REQ-008 wb_sel_i  input  4  byte enables; bit k selects wb_dat_i[8k+7:8k].
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_dat_o  output  32  read data, valid while wb_ack_o is high.
REQ-011 wb_ack_o  output  1  one-cycle transfer acknowledge.
REQ-012 ram_wen_o  output  1  RAM byte write enable, high active.
REQ-013 ram_adr_o  output  9  RAM byte address {word, k}.
REQ-014 ram_dat_o  output  8  RAM write byte.
REQ-015 ram_dat_i  input  8  RAM read byte; valid one cycle after its address is presented.

Function
REQ-016 The block SHALL serialize each 32-bit Wishbone access into four byte accesses to a 512x8 synchronous RAM, byte k = 0..3 in ascending order (little-endian).
REQ-017 FSM states SHALL be IDLE, WR, RD, RD_LAST, ACK; a 2-bit byte counter k SHALL index WR/RD.
REQ-018 In IDLE with wb_cyc_i & wb_stb_i high at an edge (cycle t0), the block SHALL latch adr, we, sel, dat, clear k, and enter WR (we=1) or RD (we=0).
REQ-019 WR, cycles t1..t4: ram_adr_o = {adr_q, k}, ram_dat_o = dat_q byte k, ram_wen_o = sel_q[k]; k increments each cycle; after k=3 go to ACK.
REQ-020 Write: wb_ack_o SHALL be high in t5 only (ACK state), then IDLE in t6.
REQ-021 RD, cycles t1..t4: ram_adr_o = {adr_q, k}, ram_wen_o = 0; after k=3 go to RD_LAST (t5).
REQ-022 Read: ram_dat_i SHALL be captured into byte k of the read register at the end of cycle t(k+2); byte 3 captured at end of RD_LAST.
REQ-023 Read: wb_ack_o high in t6 only with wb_dat_o = assembled word; all four bytes are read regardless of wb_sel_i.
REQ-024 wb_dat_o SHALL hold the last completed read word until the next read completes (including through writes).
REQ-025 Outside WR: ram_wen_o = 0 and ram_dat_o = 0; in IDLE and ACK ram_adr_o = 0.
REQ-026 Abort: wb_cyc_i low at any edge in WR/RD/RD_LAST SHALL return to IDLE next cycle with no ack; bytes already written remain; wb_dat_o unchanged.
REQ-027 A request still asserted in the IDLE cycle after ACK SHALL be accepted as a new transfer.
REQ-028 wb_stb_i low with wb_cyc_i high SHALL not start a transfer; inputs are ignored outside IDLE.
REQ-029 Word address 127 byte 3 SHALL map to ram_adr_o = 511; no wrap beyond one word occurs.

Reset
REQ-030 While rst_in is low: state IDLE, k = 0, wb_ack_o = 0, wb_dat_o = 0, ram_wen_o = 0, ram_adr_o = 0, ram_dat_o = 0, latched request cleared.
REQ-031 Reset asserted mid-transfer SHALL abort immediately with no ack; first request after release behaves as from power-up.

Verification
REQ-032 Write adr=5, sel=4'hF, dat=32'hA1B2C3D4 -> ram_wen_o high t1..t4 at adr 20..23 with bytes D4,C3,B2,A1; wb_ack_o only in t5.
REQ-033 Read adr=5 after REQ-032 (RAM model 1-cycle) -> ram_adr_o 20..23 in t1..t4, wb_ack_o only in t6 with wb_dat_o = 32'hA1B2C3D4.
REQ-034 Write adr=127, sel=4'b0101, dat=32'h11223344 -> ram_wen_o high only at 508 (44) and 510 (22); read back word -> bytes 509/511 unchanged.
REQ-035 Write adr=3, wb_cyc_i dropped after t2 -> only bytes 12,13 written, no ack, IDLE next cycle; following read adr=3 completes normally.
REQ-036 rst_in low during RD t3 -> all outputs 0 asynchronously, no ack; after release a read returns correct data.
REQ-037 Back-to-back: stb held after ack -> second transfer starts in the cycle after ACK, ack spacing 6 (write) / 7 (read) cycles.
